// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: stages channel-interleaved samples into whole frames and pops one frame per sample_tick.
module audio_frame_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 256,
  parameter int CHANNELS = 2,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic                         sample_tick,
  output logic [CHANNELS*DATA_W-1:0]   frame_out,
  output logic                         frame_valid,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clear
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int FW = CHANNELS * DATA_W;
  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] stage_q, stage_d, frame_q, frame_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ch_idx_q, ch_idx_d;
  logic [LW-1:0] level_q, level_d;
  logic fv_q, fv_d, of_q, of_d, uf_q, uf_d;
  logic accept, commit, pop, last_ch;
  // the committed frame is the staging slots with the final sample merged in
  always_comb begin
    full = level_q == LW'(DEPTH);
    empty = level_q == '0;
    wr_ready = !full;
    accept = wr_valid && wr_ready;
    last_ch = ch_idx_q == CW'(CHANNELS - 1);
    commit = accept && last_ch;
    pop = sample_tick && !empty;
    stage_d = stage_q;
    if (accept) stage_d[ch_idx_q*DATA_W +: DATA_W] = wr_data;
    ch_idx_d = !accept ? ch_idx_q : last_ch ? '0 : ch_idx_q + CW'(1);
    wr_ptr_d = wr_ptr_q + AW'(commit);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d = level_q + LW'(commit) - LW'(pop);
    frame_d = pop ? mem[rd_ptr_q] : (sample_tick && UNDERRUN_ZERO) ? '0 : frame_q;
    fv_d = pop;
    of_d = (wr_valid && !wr_ready) || (of_q && !err_clear);
    uf_d = (sample_tick && empty) || (uf_q && !err_clear);
  end
  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr_q] <= stage_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      frame_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ch_idx_q <= '0;
      level_q <= '0;
      fv_q <= 1'b0;
      of_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      frame_q <= frame_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ch_idx_q <= ch_idx_d;
      level_q <= level_d;
      fv_q <= fv_d;
      of_q <= of_d;
      uf_q <= uf_d;
    end
  end
  assign frame_out = frame_q;
  assign frame_valid = fv_q;
  assign level = level_q;
  assign overflow = of_q;
  assign underflow = uf_q;
endmodule

// File: doc/audio_frame_fifo.md
AUDIO_FRAME_FIFO -- requirements
Module: audio_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bits per audio sample.
REQ-002 SHALL have parameter DEPTH, default 256, frames stored; must be a power of two, at least 2.
REQ-003 SHALL have parameter CHANNELS, default 2, samples per frame; must be at least 1.
REQ-004 SHALL have parameter UNDERRUN_ZERO, default 0, where 0 means hold the last frame on underrun and 1 means output zero.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port wr_data, input, DATA_W bits: one sample, channel-interleaved (ch0 first).
REQ-008 SHALL have port wr_valid, input, 1 bit: wr_data is presented.
REQ-009 SHALL have port wr_ready, output, 1 bit: a sample can be accepted this cycle.
REQ-010 SHALL have port sample_tick, input, 1 bit: playback-rate request to pop one frame.
REQ-011 SHALL have port frame_out, output, CHANNELS*DATA_W bits: the popped frame, with ch0 in the LSBs.
REQ-012 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when frame_out is updated by a pop.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1 bits: committed frames held.
REQ-014 SHALL have ports full and empty, outputs, 1 bit each: level==DEPTH and level==0 respectively.
REQ-015 SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.
REQ-016 SHALL have port err_clear, input, 1 bit: clears both sticky flags.

Function
REQ-017 SHALL drive wr_ready = !full, combinationally.
REQ-018 SHALL accept a sample when wr_valid && wr_ready, storing it in the staging slot given by the channel index ch_idx, then incrementing ch_idx.
REQ-019 SHALL, when ch_idx==CHANNELS-1 and a sample is accepted, write the staged samples plus wr_data into memory at wr_ptr as one frame in the same clock, increment wr_ptr modulo DEPTH, and reset ch_idx to 0.
REQ-020 SHALL exclude partially staged frames from level, full and empty.
REQ-021 SHALL, on sample_tick && !empty, load frame_out from memory at rd_ptr, pulse frame_valid on the next cycle (1-cycle latency), and increment rd_ptr modulo DEPTH.
REQ-022 SHALL, on sample_tick && empty, keep frame_valid at 0, set underflow, and either hold frame_out (UNDERRUN_ZERO=0) or load all zeros (UNDERRUN_ZERO=1).
REQ-023 SHALL set overflow on any wr_valid && !wr_ready; the sample is dropped and ch_idx is unchanged.
REQ-024 SHALL, when a frame commit and a pop occur in the same cycle, leave level unchanged.
REQ-025 SHALL evaluate empty before the commit in the same cycle; if level==0 and commit and tick coincide, the tick underflows and the frame is stored (level becomes 1).
REQ-026 SHALL accept no write while full, even if a pop occurs in the same cycle.
REQ-027 SHALL clear the sticky flags on err_clear, except that a flag whose set condition occurs in the same cycle SHALL be set (set wins).
REQ-028 SHALL have pointers wrap silently; level is a separate counter in the range 0..DEPTH.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: wr_ptr, rd_ptr, ch_idx and level to 0; frame_out to 0; frame_valid, overflow and underflow to 0; empty=1; full=0; wr_ready=1.
REQ-030 SHALL discard memory contents and any partial frame on reset; a frame half-written when rst_n asserts is lost.
REQ-031 SHALL leave memory contents uninitialised; they are never visible before a commit.

Verification
REQ-032 Basic stereo: write 0x1111, 0x2222, then tick -> level goes 0->1->0; on the cycle after the tick frame_out=0x22221111 and frame_valid=1 for one cycle.
REQ-033 Partial frame: write only 0xAAAA, then tick -> underflow=1, frame_valid=0, level=0; then write 0xBBBB and tick -> frame_out=0xBBBBAAAA.
REQ-034 Fill/overflow (DEPTH=4): commit 4 frames -> full=1, wr_ready=0; one further write -> overflow=1 and level stays 4; pop all 4 -> data is in FIFO order and empty=1.
REQ-035 Simultaneous: at level=2, a commit and a tick in the same cycle -> level stays 2; err_clear with a concurrent underflow -> underflow remains 1.
REQ-036 Underrun mode: UNDERRUN_ZERO=1, tick on empty after frame 0x12345678 -> frame_out=0; with UNDERRUN_ZERO=0 -> frame_out stays 0x12345678.
REQ-037 Reset mid-operation: assert rst_n=0 at level=3 with ch_idx=1 -> all outputs reach their reset values without a clock edge; after release, the next two writes form frame 0.
